// File: rtl/fdiv_issue_ctrl.sv
// fdiv_issue_ctrl
// Requester-side sequencer for the iterative FP divide unit.
// It accepts one divide request from dispatch and holds the operands in
// registers. While the unit works it holds the level enable high. When the
// unit pulses ready it captures the result, then offers that result to
// writeback until writeback accepts it. A watchdog ends a request that
// never completes and returns a quiet NaN with the error flag set.
//
// Ports
//   clk_i, reset_i         clock, synchronous active-high reset
//   flush_i                abort the in-flight request and discard its result
//   reqValid_i/reqReady_o  dispatch handshake (ready only in IDLE)
//   reqRs1*/reqRs2*/reqRm_i/reqTag_i  request operands, rounding mode, tag
//   divEnable_o            level enable to the divide unit (high in BUSY)
//   divRs1*/divRs2*/divRm_o  registered operand copies for the unit
//   divReady_i/divResult_i completion pulse and result from the unit
//   rspValid_o/rspReady_i  writeback handshake
//   rspData_o/rspTag_o/rspErr_o  captured result, its tag, timeout flag
//   stall_o                pipeline stall (BUSY, or RESP while unaccepted)
module fdiv_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               reqValid_i,
    output logic               reqReady_o,
    input  logic [31:0]        reqRs1_i,
    input  logic [31:0]        reqRs2_i,
    input  logic signed [9:0]  reqRs1Exp_i,
    input  logic signed [9:0]  reqRs2Exp_i,
    input  logic [23:0]        reqRs1Sig_i,
    input  logic [23:0]        reqRs2Sig_i,
    input  logic [5:0]         reqRs1Class_i,
    input  logic [5:0]         reqRs2Class_i,
    input  logic [2:0]         reqRm_i,
    input  logic [TAG_W-1:0]   reqTag_i,
    output logic               divEnable_o,
    output logic [31:0]        divRs1_o,
    output logic [31:0]        divRs2_o,
    output logic signed [9:0]  divRs1Exp_o,
    output logic signed [9:0]  divRs2Exp_o,
    output logic [23:0]        divRs1Sig_o,
    output logic [23:0]        divRs2Sig_o,
    output logic [5:0]         divRs1Class_o,
    output logic [5:0]         divRs2Class_o,
    output logic [2:0]         divRm_o,
    input  logic               divReady_i,
    input  logic [31:0]        divResult_i,
    output logic               rspValid_o,
    input  logic               rspReady_i,
    output logic [31:0]        rspData_o,
    output logic [TAG_W-1:0]   rspTag_o,
    output logic               rspErr_o,
    output logic               stall_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]     QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WD_W-1:0]    r_wd;
    logic               w_accept;
    logic               w_done;
    logic               w_timeout;

    logic [31:0]        r_rs1, r_rs2;
    logic signed [9:0]  r_rs1_exp, r_rs2_exp;
    logic [23:0]        r_rs1_sig, r_rs2_sig;
    logic [5:0]         r_rs1_cls, r_rs2_cls;
    logic [2:0]         r_rm;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;

    // Flush overrides everything, so a ready pulse or a request in the
    // flush cycle is simply never looked at.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reqValid_i) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A real completion wins over a timeout on the same edge.
                    if (divReady_i) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_RESP;
                    end else if (r_wd >= WD_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
                S_RESP: begin
                    if (rspReady_i) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_wd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rs1_exp  <= '0;
            r_rs2_exp  <= '0;
            r_rs1_sig  <= '0;
            r_rs2_sig  <= '0;
            r_rs1_cls  <= '0;
            r_rs2_cls  <= '0;
            r_rm       <= '0;
            r_tag      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_i) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b0;
                r_tag      <= '0;
            end else begin
                if (w_accept) begin
                    r_rs1     <= reqRs1_i;
                    r_rs2     <= reqRs2_i;
                    r_rs1_exp <= reqRs1Exp_i;
                    r_rs2_exp <= reqRs2Exp_i;
                    r_rs1_sig <= reqRs1Sig_i;
                    r_rs2_sig <= reqRs2Sig_i;
                    r_rs1_cls <= reqRs1Class_i;
                    r_rs2_cls <= reqRs2Class_i;
                    r_rm      <= reqRm_i;
                    r_tag     <= reqTag_i;
                    r_wd      <= '0;
                end else if (r_state == S_BUSY && r_wd != WD_MAX) begin
                    r_wd <= r_wd + 1'b1;
                end
                if (w_done) begin
                    r_rsp_data <= divResult_i;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= QNAN;
                    r_rsp_err  <= 1'b1;
                end
            end
        end
    end

    // Control outputs decode straight from state: enable drops on the very
    // edge that sees ready, and stays low through RESP and at least one
    // IDLE cycle, giving the unit time to rearm.
    assign reqReady_o    = (r_state == S_IDLE);
    assign divEnable_o   = (r_state == S_BUSY);
    assign rspValid_o    = (r_state == S_RESP);
    assign stall_o       = (r_state == S_BUSY) || (r_state == S_RESP);

    assign divRs1_o      = r_rs1;
    assign divRs2_o      = r_rs2;
    assign divRs1Exp_o   = r_rs1_exp;
    assign divRs2Exp_o   = r_rs2_exp;
    assign divRs1Sig_o   = r_rs1_sig;
    assign divRs2Sig_o   = r_rs2_sig;
    assign divRs1Class_o = r_rs1_cls;
    assign divRs2Class_o = r_rs2_cls;
    assign divRm_o       = r_rm;

    assign rspData_o     = r_rsp_data;
    assign rspTag_o      = r_tag;
    assign rspErr_o      = r_rsp_err;

endmodule
